// File: rtl/bank_req_queue.sv
// Per-bank show-ahead request FIFO feeding the 16-bank arbiter; pops on the arbiter's ack.
// Optional QUEUE_STATS_EN adds a saturating drop counter and an occupancy high-watermark.
module bank_req_queue #(
    parameter int REQ_SIZE = 32,
    parameter int DEPTH    = 8,
    parameter int PTR_W    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [REQ_SIZE-1:0] push_data,
    output logic                full,
    input  logic                ack,
    output logic                req,
    output logic                valid,
    output logic [REQ_SIZE-1:0] data_out,
    output logic [PTR_W:0]      count,
    output logic                err_ack
`ifdef QUEUE_STATS_EN
    ,
    output logic [7:0]          drop_cnt,
    output logic [PTR_W:0]      max_occ
`endif
);

    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W+1)'(1);
    localparam logic [PTR_W:0]   CNT_TWO   = (PTR_W+1)'(2);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    logic [REQ_SIZE-1:0] mem [DEPTH];

    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]      count_q, count_d;
    logic                full_q, full_d;
    logic                req_q, req_d;
    logic                valid_q, valid_d;
    logic [REQ_SIZE-1:0] data_q, data_d;
    logic                err_q, err_d;
    logic                push_acc;
    logic                pop_acc;

    // A full queue still accepts a push when the same-cycle ack frees the head slot.
    assign push_acc = push && (!full_q || ack);
    assign pop_acc  = ack && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_d    = err_q;

        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push_acc && !pop_acc) begin
            count_d = count_q + CNT_ONE;
        end else if (pop_acc && !push_acc) begin
            count_d = count_q - CNT_ONE;
        end
        if (ack && (count_q == '0)) begin
            err_d = 1'b1;
        end

        req_d   = (count_d != '0);
        valid_d = (count_d >= CNT_TWO);
        full_d  = (count_d == DEPTH_CNT);

        // The new head may be the word being written this very edge, so bypass the array.
        if (count_d == '0) begin
            data_d = '0;
        end else if (push_acc && (rd_ptr_d == wr_ptr_q)) begin
            data_d = push_data;
        end else begin
            data_d = mem[rd_ptr_d];
        end
    end

    // NOTE: the storage array has no reset; req/count gate every read, so stale words are never exposed.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            req_q    <= req_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            err_q    <= err_d;
        end
    end

    assign full     = full_q;
    assign req      = req_q;
    assign valid    = valid_q;
    assign data_out = data_q;
    assign count    = count_q;
    assign err_ack  = err_q;

`ifdef QUEUE_STATS_EN
    logic [7:0]     drop_q, drop_d;
    logic [PTR_W:0] max_q, max_d;

    always_comb begin
        drop_d = drop_q;
        max_d  = max_q;
        if (push && full_q && !ack && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
        if (count_d > max_q) begin
            max_d = count_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= '0;
            max_q  <= '0;
        end else begin
            drop_q <= drop_d;
            max_q  <= max_d;
        end
    end

    assign drop_cnt = drop_q;
    assign max_occ  = max_q;
`endif

endmodule

// File: tb/tb_bank_req_queue.sv
// Self-checking bench for bank_req_queue: directed scenarios plus randomized traffic
// compared each cycle against a queue-based reference model.
module tb_bank_req_queue;

    localparam int REQ_SIZE = 32;
    localparam int DEPTH    = 8;
    localparam int PTR_W    = $clog2(DEPTH);

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                push = 1'b0;
    logic [REQ_SIZE-1:0] push_data = '0;
    logic                ack = 1'b0;
    logic                full, req, valid, err_ack;
    logic [REQ_SIZE-1:0] data_out;
    logic [PTR_W:0]      count;
`ifdef QUEUE_STATS_EN
    logic [7:0]          drop_cnt;
    logic [PTR_W:0]      max_occ;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [REQ_SIZE-1:0] m_q[$];
    bit                  m_err;
    int                  m_drop;
    int                  m_max;

    always #5 clk = ~clk;

    bank_req_queue #(.REQ_SIZE(REQ_SIZE), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .full      (full),
        .ack       (ack),
        .req       (req),
        .valid     (valid),
        .data_out  (data_out),
        .count     (count),
        .err_ack   (err_ack)
`ifdef QUEUE_STATS_EN
        ,
        .drop_cnt  (drop_cnt),
        .max_occ   (max_occ)
`endif
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_clear();
        m_q.delete();
        m_err  = 1'b0;
        m_drop = 0;
        m_max  = 0;
    endfunction

    // One clock: drive inputs, advance the model from pre-edge state, then compare all outputs.
    task automatic cycle(input logic p, input logic [REQ_SIZE-1:0] d, input logic a);
        bit was_full, was_empty;
        logic [REQ_SIZE-1:0] exp_data;
        push = p; push_data = d; ack = a;
        @(posedge clk);
        was_full  = (m_q.size() == DEPTH);
        was_empty = (m_q.size() == 0);
        if (a && was_empty) m_err = 1'b1;
        if (p && was_full && !a && m_drop < 255) m_drop++;
        if (a && !was_empty) void'(m_q.pop_front());
        if (p && (!was_full || a)) m_q.push_back(d);
        if (m_q.size() > m_max) m_max = m_q.size();
        exp_data = (m_q.size() != 0) ? m_q[0] : '0;
        #1;
        push = 1'b0; ack = 1'b0;
        checks += 6;
        if (count !== (PTR_W+1)'(m_q.size())) begin
            errors++; $display("FAIL count: got %0d expected %0d", count, m_q.size());
        end
        if (req !== (m_q.size() != 0)) begin
            errors++; $display("FAIL req: got %b expected %b", req, m_q.size() != 0);
        end
        if (valid !== (m_q.size() >= 2)) begin
            errors++; $display("FAIL valid: got %b expected %b", valid, m_q.size() >= 2);
        end
        if (full !== (m_q.size() == DEPTH)) begin
            errors++; $display("FAIL full: got %b expected %b", full, m_q.size() == DEPTH);
        end
        if (data_out !== exp_data) begin
            errors++; $display("FAIL data_out: got %h expected %h", data_out, exp_data);
        end
        if (err_ack !== m_err) begin
            errors++; $display("FAIL err_ack: got %b expected %b", err_ack, m_err);
        end
`ifdef QUEUE_STATS_EN
        checks += 2;
        if (drop_cnt !== 8'(m_drop)) begin
            errors++; $display("FAIL drop_cnt: got %0d expected %0d", drop_cnt, m_drop);
        end
        if (max_occ !== (PTR_W+1)'(m_max)) begin
            errors++; $display("FAIL max_occ: got %0d expected %0d", max_occ, m_max);
        end
`endif
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if (count !== '0 || req !== 1'b0 || valid !== 1'b0 || full !== 1'b0 ||
            data_out !== '0 || err_ack !== 1'b0) begin
            errors++;
            $display("FAIL %s: got count=%0d req=%b valid=%b full=%b data=%h err=%b expected all zero",
                     tag, count, req, valid, full, data_out, err_ack);
        end
`ifdef QUEUE_STATS_EN
        checks++;
        if (drop_cnt !== 8'd0 || max_occ !== '0) begin
            errors++;
            $display("FAIL %s_stats: got drop=%0d max=%0d expected 0", tag, drop_cnt, max_occ);
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        check_idle_outputs("reset_state");
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        cycle(1'b0, '0, 1'b0);
    endtask

    task automatic test_single_push();
        cycle(1'b1, 32'hA5A5_0001, 1'b0);
        cycle(1'b0, '0, 1'b1);
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, REQ_SIZE'(i), 1'b0);
        cycle(1'b1, 32'hDEAD_BEEF, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (data_out !== REQ_SIZE'(i)) begin
                errors++; $display("FAIL drain_order: got %h expected %h", data_out, i);
            end
            cycle(1'b0, '0, 1'b1);
        end
    endtask

    task automatic test_push_pop_full();
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, REQ_SIZE'(32'h100 + i), 1'b0);
        cycle(1'b1, 32'h99, 1'b1);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == DEPTH - 1) begin
                checks++;
                if (data_out !== 32'h99) begin
                    errors++; $display("FAIL full_pushpop_tail: got %h expected 00000099", data_out);
                end
            end
            cycle(1'b0, '0, 1'b1);
        end
    endtask

    task automatic test_wrap();
        cycle(1'b1, 32'h2000, 1'b0);
        for (int i = 1; i <= 10; i++) cycle(1'b1, REQ_SIZE'(32'h2000 + i), 1'b1);
        cycle(1'b0, '0, 1'b1);
    endtask

    task automatic test_ack_empty();
        cycle(1'b0, '0, 1'b1);
        cycle(1'b1, 32'h3000, 1'b0);
        cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) cycle(1'b1, REQ_SIZE'(32'h4000 + i), 1'b0);
        @(negedge clk);
        push = 1'b1; push_data = 32'h4444; ack = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_idle_outputs("reset_mid_async");
        @(posedge clk);
        #1;
        check_idle_outputs("reset_mid_held");
        @(negedge clk);
        push = 1'b0; ack = 1'b0; rst = 1'b0;
        model_clear();
        cycle(1'b0, '0, 1'b0);
    endtask

    task automatic test_random();
        for (int phase = 0; phase < 3; phase++) begin
            for (int i = 0; i < 100; i++) begin
                logic p, a;
                p = ($urandom_range(0, 3) < (phase == 0 ? 3 : (phase == 1 ? 1 : 2)));
                a = ($urandom_range(0, 3) < (phase == 0 ? 1 : (phase == 1 ? 3 : 2)));
                cycle(p, REQ_SIZE'($urandom), a);
            end
        end
    endtask

`ifdef QUEUE_STATS_EN
    task automatic test_stats();
        for (int i = 0; i < DEPTH + 300; i++) cycle(1'b1, REQ_SIZE'(i), 1'b0);
        checks += 2;
        if (drop_cnt !== 8'd255) begin
            errors++; $display("FAIL drop_saturate: got %0d expected 255", drop_cnt);
        end
        if (max_occ !== (PTR_W+1)'(DEPTH)) begin
            errors++; $display("FAIL max_occ_full: got %0d expected %0d", max_occ, DEPTH);
        end
        test_reset_mid();
    endtask
`endif

    initial begin
        model_clear();
        test_reset();
        test_single_push();
        test_fill_drain();
        test_push_pop_full();
        test_wrap();
        test_ack_empty();
        test_reset_mid();
        test_random();
`ifdef QUEUE_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
